// File: rtl/magic_packet_injector.sv
// Producer side of the FIFO data-integrity check: pushes a burst of sequence-numbered
// packets with one magic packet at a programmed index, then waits for the FIFO to drain.
module magic_packet_injector #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int PKTW   = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [PKTW-1:0]   num_pkts,
    input  logic [PKTW-1:0]   magic_idx,
    input  logic [WIDTH-1:0]  magic_val,
    input  logic              full,
    input  logic              pop,
    output logic              push,
    output logic [WIDTH-1:0]  data_out,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic [CNTWID-1:0] outstanding,
    output logic              magic_sent,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNTWID-1:0] DEPTH_C = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0] CNT_ONE = CNTWID'(1);
    localparam logic [WIDTH-1:0]  BIT0    = WIDTH'(1);
    localparam logic [PKTW-1:0]   PKT_ONE = PKTW'(1);

    state_t             state_q, state_d;
    logic [PKTW-1:0]    seq_q, seq_d;
    logic [PKTW-1:0]    num_q, num_d;
    logic [PKTW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic [CNTWID-1:0]  outstanding_q, outstanding_d;
    logic               magic_sent_q, magic_sent_d;
    logic [WIDTH-1:0]   filler;
    logic               is_magic;

    if (PKTW >= WIDTH) begin : g_trunc
        assign filler = seq_q[WIDTH-1:0];
    end else begin : g_zext
        assign filler = {{(WIDTH-PKTW){1'b0}}, seq_q};
    end

    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        num_d         = num_q;
        idx_d         = idx_q;
        val_d         = val_q;
        magic_sent_d  = magic_sent_q;
        outstanding_d = outstanding_q;

        is_magic = (seq_q == idx_q);
        push     = (state_q == SEND) && !full && (outstanding_q < DEPTH_C);
        start    = push && is_magic;
        // Filler that would alias the magic value is flipped so only the real magic packet matches.
        if (is_magic)
            data_out = val_q;
        else if (filler == val_q)
            data_out = val_q ^ BIT0;
        else
            data_out = filler;

        case (state_q)
            IDLE: begin
                if (go) begin
                    num_d        = num_pkts;
                    idx_d        = magic_idx;
                    val_d        = magic_val;
                    seq_d        = '0;
                    magic_sent_d = 1'b0;
                    state_d      = (num_pkts == '0) ? DRAIN : SEND;
                end
            end
            SEND: begin
                if (push) begin
                    seq_d = seq_q + PKT_ONE;
                    if (is_magic) magic_sent_d = 1'b1;
                    if (seq_q == num_q - PKT_ONE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_q == '0) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Occupancy follows every observed push/pop, independent of FSM state.
        if (push && !pop && (outstanding_q < DEPTH_C))
            outstanding_d = outstanding_q + CNT_ONE;
        else if (pop && !push && (outstanding_q != '0))
            outstanding_d = outstanding_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            seq_q         <= '0;
            num_q         <= '0;
            idx_q         <= '0;
            val_q         <= '0;
            outstanding_q <= '0;
            magic_sent_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_q         <= seq_d;
            num_q         <= num_d;
            idx_q         <= idx_d;
            val_q         <= val_d;
            outstanding_q <= outstanding_d;
            magic_sent_q  <= magic_sent_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign outstanding = outstanding_q;
    assign magic_sent  = magic_sent_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_magic_packet_injector.sv
// Randomized bench for magic_packet_injector: a packet-list model predicts every push,
// and an occupancy/phase model predicts busy, done, outstanding and magic_sent.
module tb_magic_packet_injector;

    localparam int DEPTH  = 8;
    localparam int WIDTH  = 8;
    localparam int PKTW   = 8;
    localparam int CNTWID = $clog2(DEPTH) + 1;
    localparam int EW     = WIDTH + 1;  // {start, data}

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              go = 1'b0;
    logic [PKTW-1:0]   num_pkts = '0;
    logic [PKTW-1:0]   magic_idx = '0;
    logic [WIDTH-1:0]  magic_val = '0;
    logic              full = 1'b0;
    logic              pop = 1'b0;
    logic              push;
    logic [WIDTH-1:0]  data_out;
    logic              start;
    logic              busy;
    logic              done;
    logic [CNTWID-1:0] outstanding;
    logic              magic_sent;
    logic [1:0]        state_dbg;

    magic_packet_injector #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .PKTW(PKTW), .CNTWID(CNTWID)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .num_pkts(num_pkts), .magic_idx(magic_idx),
        .magic_val(magic_val), .full(full), .pop(pop), .push(push), .data_out(data_out),
        .start(start), .busy(busy), .done(done), .outstanding(outstanding),
        .magic_sent(magic_sent), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [EW-1:0] exp_q[$];
    bit            in_burst   = 0;
    bit            done_pend  = 0;
    bit            msent      = 0;
    int            occ        = 0;
    int            burst_pushes = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic build_burst(input int n, input int idx, input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] f;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            f = WIDTH'(i);
            if (i == idx)   exp_q.push_back({1'b1, val});
            else if (f == val) exp_q.push_back({1'b0, val ^ 8'h01});
            else            exp_q.push_back({1'b0, f});
        end
    endtask

    // Sample at negedge, compare, then advance the model to the next cycle.
    task automatic model_step();
        bit exp_done, exp_push, exp_start, was_burst, q_empty;
        logic [EW-1:0] e;
        exp_done  = done_pend;
        done_pend = 0;
        was_burst = in_burst;
        q_empty   = (exp_q.size() == 0);
        check_eq("done", 32'(done), 32'(exp_done));
        check_eq("busy", 32'(busy), 32'(in_burst));
        check_eq("outstanding", 32'(outstanding), 32'(occ));
        check_eq("magic_sent", 32'(magic_sent), 32'(msent));
        exp_push  = in_burst && !q_empty && !full && (occ < DEPTH);
        check_eq("push", 32'(push), 32'(exp_push));
        exp_start = 0;
        if (push && !q_empty) begin
            e = exp_q.pop_front();
            check_eq("data_out", 32'(data_out), 32'(e[WIDTH-1:0]));
            exp_start = e[WIDTH];
            burst_pushes++;
        end
        check_eq("start", 32'(start), 32'(exp_start));
        if (exp_start) msent = 1;
        if (exp_done) in_burst = 0;
        else if (in_burst && q_empty && occ == 0) done_pend = 1;
        if (push && !pop && occ < DEPTH) occ++;
        else if (pop && !push && occ > 0) occ--;
        if (go && !was_burst) begin
            in_burst     = 1;
            msent        = 0;
            burst_pushes = 0;
            build_burst(int'(num_pkts), int'(magic_idx), magic_val);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        go  = 1'b0;
        pop = 1'b0;
        full = 1'b0;
        #1;
        check_eq("rst_push", 32'(push), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_start", 32'(start), 0);
        check_eq("rst_outstanding", 32'(outstanding), 0);
        check_eq("rst_magic_sent", 32'(magic_sent), 0);
        check_eq("rst_state_idle", 32'(state_dbg), 0);
        exp_q.delete();
        in_burst = 0; done_pend = 0; msent = 0; occ = 0; burst_pushes = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic idle_cycles(input int k);
        go = 1'b0;
        for (int i = 0; i < k; i++) begin
            full = 1'($urandom_range(0, 1));
            pop  = 1'($urandom_range(0, 1));
            tick();
        end
        pop = 1'b0;
        full = 1'b0;
    endtask

    task automatic run_burst(input int n, input int idx, input int val, input int full_pct,
                             input int pop_pct, input int hold_pop, input bit stall_magic,
                             input int abort_after);
        int cyc;
        bit stalled;
        cyc = 0;
        stalled = 0;
        num_pkts  = PKTW'(n);
        magic_idx = PKTW'(idx);
        magic_val = WIDTH'(val);
        go = 1'b1; full = 1'b0; pop = 1'b0;
        tick();
        go = 1'b0;
        while (in_burst && cyc < 3000) begin
            if (abort_after >= 0 && burst_pushes >= abort_after) begin
                do_reset();
                return;
            end
            if (cyc == hold_pop && full_pct == 0 && hold_pop >= ((n < DEPTH) ? n : DEPTH) + 2)
                check_eq("hold_occ", 32'(outstanding), 32'((n < DEPTH) ? n : DEPTH));
            full = ($urandom_range(0, 99) < full_pct);
            if (stall_magic && !stalled && exp_q.size() > 0 && exp_q[0][WIDTH]) begin
                full = 1'b1;
                stalled = 1;
            end
            pop = (cyc >= hold_pop) && ($urandom_range(0, 99) < pop_pct);
            // Stray go requests and changing fields mid-burst must be ignored.
            go = ($urandom_range(0, 9) == 0);
            if (go) begin
                num_pkts  = PKTW'($urandom);
                magic_idx = PKTW'($urandom);
                magic_val = WIDTH'($urandom);
            end
            tick();
            cyc++;
        end
        go = 1'b0; pop = 1'b0; full = 1'b0;
        if (cyc >= 3000) check_eq("burst_timeout", 1, 0);
    endtask

    initial begin
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        do_reset();
        idle_cycles(3);

        // Basic burst, pops held until all four pushes are in.
        run_burst(4, 2, 'hA5, 0, 100, 7, 0, -1);
        idle_cycles(2);
        // Backpressure: 12 packets into a depth-8 FIFO, pops released later.
        run_burst(12, 9, 'h3C, 0, 100, 16, 0, -1);
        idle_cycles(2);
        // Full asserted exactly on the magic packet.
        run_burst(6, 3, 'h77, 0, 60, 0, 1, -1);
        idle_cycles(2);
        // Filler collision with the magic value.
        run_burst(4, 3, 'h01, 0, 100, 6, 0, -1);
        idle_cycles(2);
        // Empty burst and out-of-range magic index.
        run_burst(0, 0, 'h55, 0, 100, 0, 0, -1);
        idle_cycles(2);
        run_burst(4, 7, 'h02, 0, 100, 6, 0, -1);
        idle_cycles(2);
        // Reset mid-burst after two pushes, then a clean restart.
        run_burst(6, 4, 'h90, 0, 0, 100, 0, 2);
        run_burst(6, 4, 'h90, 0, 100, 8, 0, -1);
        idle_cycles(2);

        for (int b = 0; b < 14; b++) begin
            run_burst(int'($urandom_range(0, 20)), int'($urandom_range(0, 24)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 40)),
                      int'($urandom_range(30, 90)), int'($urandom_range(0, 10)),
                      1'($urandom_range(0, 1)), -1);
            idle_cycles(int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
